conv_output_collector: RTL
==========================

Name: conv_output_collector

Overview:
- Receiving end of the convolution layer's output stream. Consumes `data_out`, `valid_op` and `end_op` from `layer`.
- Buffers one output feature map of N×N words in an internal synchronous RAM, where N = (W-K)/s+1.
- Once the map is complete, replays it in raster order over a valid/ready read port for pooling, the next layer or a bench scoreboard.

Parameters:
- dataWidth, 16, word width of every data sample.
- W, 28, input feature-map width in pixels. The map is square.
- K, 3, kernel size.
- s, 1, convolution stride.
- Derived localparams, not overridable:
  - N = (W-K)/s+1.
  - DEPTH = N*N.
  - AW = clog2(DEPTH), minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- global_rst  input  1  asynchronous, active-low reset; low clears all state.
- ce  input  1  clock enable; when low, all registers hold.
- data_in  input  dataWidth  layer output word (`data_out`).
- valid_in  input  1  layer output valid (`valid_op`).
- end_in  input  1  layer end-of-frame (`end_op`).
- rd_ready  input  1  downstream ready.
- rd_data  output  dataWidth  buffered word.
- rd_valid  output  1  rd_data is valid.
- rd_last  output  1  rd_data is the final word of the frame.
- rd_row  output  AW  row index of rd_data.
- rd_col  output  AW  column index of rd_data.
- frame_full  output  1  high for the whole DRAIN state.
- overflow  output  1  sticky error flag.
- wr_count  output  AW+1  number of words stored in the current frame.

Behaviour:
Reset (global_rst low):
- State is FILL.
- wr_count, read pointer, rd_data, rd_valid, rd_last, rd_row, rd_col, frame_full and overflow are all 0.
- RAM contents are not reset.
- Reset asserted mid-frame or mid-drain discards the frame immediately.

Clock enable:
- All transitions below are qualified by ce=1. With ce=0, everything holds, including a pending rd_valid.

State FILL:
- Write condition is valid_in=1 AND end_in=0. On it: RAM[wr_count] <= data_in and wr_count increments.
- valid_in=1 with end_in=1 in the same cycle: end takes precedence and the word is not stored.
- When the write that makes wr_count == DEPTH occurs, go to DRAIN on the next edge.
- end_in=1 with 0 < wr_count < DEPTH (short frame): go to DRAIN and drain only wr_count words.
- end_in=1 with wr_count == 0: ignored; stay in FILL.
- rd_valid is 0 throughout FILL.

State DRAIN:
- frame_full=1.
- valid_in=1 with end_in=0 in DRAIN: data is not stored and overflow <= 1 (sticky until reset).
- end_in in DRAIN: ignored, and overflow is not set. This covers the late end-of-frame after an exactly full frame.
- Read latency:
  - The RAM read is synchronous.
  - The first rd_valid rises 2 cycles after entering DRAIN: 1 cycle for address, 1 for data register.
- Handshake:
  - A transfer happens when rd_valid AND rd_ready.
  - While rd_valid=1 and rd_ready=0, rd_data, rd_last, rd_row and rd_col are held stable.
  - Prefetch so that back-to-back rd_ready=1 gives one word per cycle with no bubbles.
- Indexing:
  - rd_row/rd_col track raster order. Column wraps from N-1 to 0, and row then increments.
- rd_last=1 exactly on word index wr_count-1.
- On the transfer of the last word, the next edge produces:
  - rd_valid=0, rd_last=0, frame_full=0.
  - wr_count=0 and read pointer = 0.
  - State returns to FILL.
- valid_in on the first cycle back in FILL is stored as word 0.

Arithmetic:
- Data is passed through bit-exact; there is no arithmetic on data.
- Counters are unsigned. wr_count never exceeds DEPTH.

Test Plan:
Use W=6, K=3, s=1, so N=4 and DEPTH=16.
1. Stream words 0x0001..0x0010 with valid_in=1 and rd_ready held high.
   - Required: frame_full rises after the 16th word.
   - rd_valid rises 2 cycles later. 16 consecutive beats 0x0001..0x0010.
   - rd_row/rd_col go (0,0)…(3,3); rd_last only on 0x0010.
   - Then back to FILL with wr_count=0.
2. Same fill, but toggle rd_ready 1,0,0,1,…
   - Required: rd_data, rd_last, rd_row and rd_col are stable during stalls.
   - No word is lost or duplicated; sequence still 0x0001..0x0010.
3. Write 5 words 0xA000..0xA004, then end_in=1.
   - Required: DRAIN with exactly 5 words; rd_last on 0xA004; rd_col wraps at index 4 to (1,0).
4. Fill 16 words, then valid_in=1 with data 0xBEEF during DRAIN. Separately, end_in=1 during DRAIN.
   - Required: overflow=1 and stays 1; 0xBEEF never appears on rd_data.
   - end_in alone does not set overflow.
5. Assert global_rst low asynchronously midway through a drain (after word 7).
   - Required: rd_valid, frame_full and wr_count are 0 immediately, without waiting for a clock edge.
   - A subsequent full frame drains correctly from word 0.
6. Drop ce to 0 for 3 cycles mid-fill and mid-drain, driving valid_in=1 while ce=0.
   - Required: no writes, no index advance, outputs held.
   - Final sequence is identical to scenario 1.

Source files
------------

// File: rtl/conv_output_collector.sv
// Collects one N x N convolution output map into a synchronous RAM,
// then replays it in raster order over a valid/ready read port.
module conv_output_collector #(
    parameter int dataWidth = 16,
    parameter int W = 28,
    parameter int K = 3,
    parameter int s = 1,
    localparam int N = (W - K) / s + 1,
    localparam int DEPTH = N * N,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 global_rst,
    input  logic                 ce,
    input  logic [dataWidth-1:0] data_in,
    input  logic                 valid_in,
    input  logic                 end_in,
    input  logic                 rd_ready,
    output logic [dataWidth-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 rd_last,
    output logic [AW-1:0]        rd_row,
    output logic [AW-1:0]        rd_col,
    output logic                 frame_full,
    output logic                 overflow,
    output logic [AW:0]          wr_count
);

    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic [AW:0]   FULL_M1 = (AW + 1)'(DEPTH - 1);
    localparam logic [AW-1:0] COL_MAX = AW'(N - 1);

    logic [dataWidth-1:0] mem [DEPTH];
    logic [dataWidth-1:0] mem_q;

    state_t               state_q, state_d;
    logic [AW:0]          wr_cnt_q, wr_cnt_d;
    logic [AW:0]          ptr_q, ptr_d;
    logic [AW-1:0]        irow_q, irow_d, icol_q, icol_d;
    logic                 s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic [AW-1:0]        s1_row_q, s1_row_d, s1_col_q, s1_col_d;
    logic [dataWidth-1:0] data_q, data_d;
    logic                 valid_q, valid_d, last_q, last_d;
    logic [AW-1:0]        row_q, row_d, col_q, col_d;
    logic                 ovf_q, ovf_d;
    logic                 wr_en, issue, out_rdy;

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        ptr_d     = ptr_q;
        irow_d    = irow_q;
        icol_d    = icol_q;
        s1_v_d    = s1_v_q;
        s1_last_d = s1_last_q;
        s1_row_d  = s1_row_q;
        s1_col_d  = s1_col_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        row_d     = row_q;
        col_d     = col_q;
        ovf_d     = ovf_q;
        wr_en     = 1'b0;
        issue     = 1'b0;
        out_rdy   = !valid_q || rd_ready;
        if (ce) begin
            unique case (state_q)
                FILL: begin
                    if (end_in) begin
                        if (wr_cnt_q != '0) state_d = DRAIN;
                    end else if (valid_in) begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        if (wr_cnt_q == FULL_M1) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (valid_in && !end_in) ovf_d = 1'b1;
                    // Fetch only when stage 1 is free or empties this cycle
                    issue = (ptr_q < wr_cnt_q) && (!s1_v_q || out_rdy);
                    if (s1_v_q && out_rdy) begin
                        valid_d = 1'b1;
                        data_d  = mem_q;
                        last_d  = s1_last_q;
                        row_d   = s1_row_q;
                        col_d   = s1_col_q;
                    end else if (valid_q && rd_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                    if (issue) begin
                        s1_v_d    = 1'b1;
                        s1_last_d = (ptr_q == wr_cnt_q - 1'b1);
                        s1_row_d  = irow_q;
                        s1_col_d  = icol_q;
                        ptr_d     = ptr_q + 1'b1;
                        if (icol_q == COL_MAX) begin
                            icol_d = '0;
                            irow_d = irow_q + 1'b1;
                        end else begin
                            icol_d = icol_q + 1'b1;
                        end
                    end else if (s1_v_q && out_rdy) begin
                        s1_v_d = 1'b0;
                    end
                    if (valid_q && rd_ready && last_q) begin
                        state_d  = FILL;
                        wr_cnt_d = '0;
                        ptr_d    = '0;
                        irow_d   = '0;
                        icol_d   = '0;
                        s1_v_d   = 1'b0;
                        valid_d  = 1'b0;
                        last_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            ptr_q     <= '0;
            irow_q    <= '0;
            icol_q    <= '0;
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            ptr_q     <= ptr_d;
            irow_q    <= irow_d;
            icol_q    <= icol_d;
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            s1_row_q  <= s1_row_d;
            s1_col_q  <= s1_col_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ovf_q     <= ovf_d;
        end
    end

    // RAM and its read register are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt_q[AW-1:0]] <= data_in;
        if (issue) mem_q <= mem[ptr_q[AW-1:0]];
    end

    assign rd_data    = data_q;
    assign rd_valid   = valid_q;
    assign rd_last    = last_q;
    assign rd_row     = row_q;
    assign rd_col     = col_q;
    assign frame_full = (state_q == DRAIN);
    assign overflow   = ovf_q;
    assign wr_count   = wr_cnt_q;

endmodule
